// File: rtl/mbist_march_ctrl_if.sv
// Sequencer handshake, memory port and failure report of the March C- MBIST controller.
// The controller takes the master view; the sequencer/memory side takes the slave view.
interface mbist_march_ctrl_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
);
   logic                  start;
   logic                  write_read;
   logic [ADDR_WIDTH-1:0] address;
   logic [DATA_WIDTH-1:0] wdata;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  busy;
   logic                  done;
   logic                  fail;
   logic [ADDR_WIDTH-1:0] fail_addr;
   logic [2:0]            fail_element;
   logic [DATA_WIDTH-1:0] fail_data;
   logic [CNT_WIDTH-1:0]  fail_cnt;

   modport master (
      input  start, rdata,
      output write_read, address, wdata, busy, done,
             fail, fail_addr, fail_element, fail_data, fail_cnt
   );

   modport slave (
      output start, rdata,
      input  write_read, address, wdata, busy, done,
             fail, fail_addr, fail_element, fail_data, fail_cnt
   );
endinterface

// File: rtl/mbist_march_ctrl.sv
// March C- MBIST initiator: sequences E0..E5 over 0..LAST_ADDR on a single-port memory,
// compares read data through a 2-deep tag line and reports the first miscompare plus a count.
module mbist_march_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int LAST_ADDR  = 255,
   parameter int CNT_WIDTH  = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   mbist_march_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_RUN,
      S_GAP,
      S_DRAIN,
      S_DONE
   } state_t;

   typedef struct packed {
      logic has_read;
      logic has_write;
      logic read_ones;
      logic write_ones;
      logic down;
   } elem_t;

   typedef struct packed {
      logic                  valid;
      logic [DATA_WIDTH-1:0] expected;
      logic [ADDR_WIDTH-1:0] addr;
      logic [2:0]            element;
   } tag_t;

   localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(LAST_ADDR);
   localparam logic [2:0]            ELEM_LAST = 3'd5;

   // E0 up(w0); E1 up(r0,w1); E2 up(r1,w0); E3 down(r0,w1); E4 down(r1,w0); E5 up(r0)
   function automatic elem_t elem_info(input logic [2:0] e);
      elem_t info;
      case (e)
         3'd0:    info = '{has_read: 1'b0, has_write: 1'b1, read_ones: 1'b0, write_ones: 1'b0, down: 1'b0};
         3'd1:    info = '{has_read: 1'b1, has_write: 1'b1, read_ones: 1'b0, write_ones: 1'b1, down: 1'b0};
         3'd2:    info = '{has_read: 1'b1, has_write: 1'b1, read_ones: 1'b1, write_ones: 1'b0, down: 1'b0};
         3'd3:    info = '{has_read: 1'b1, has_write: 1'b1, read_ones: 1'b0, write_ones: 1'b1, down: 1'b1};
         3'd4:    info = '{has_read: 1'b1, has_write: 1'b1, read_ones: 1'b1, write_ones: 1'b0, down: 1'b1};
         default: info = '{has_read: 1'b1, has_write: 1'b0, read_ones: 1'b0, write_ones: 1'b0, down: 1'b0};
      endcase
      return info;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] background(input logic ones);
      return {DATA_WIDTH{ones}};
   endfunction

   function automatic logic [ADDR_WIDTH-1:0] first_addr(input elem_t info);
      return info.down ? ADDR_LAST : '0;
   endfunction

   function automatic logic [ADDR_WIDTH-1:0] final_addr(input elem_t info);
      return info.down ? '0 : ADDR_LAST;
   endfunction

   state_t                state_q, state_d;
   logic [2:0]            elem_q, elem_d;
   logic                  phase_q, phase_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  drain_q, drain_d;
   tag_t                  tag1_q, tag2_q, tag_in;
   logic                  start_accept;
   logic                  write_op;
   elem_t                 cur, nxt;

   logic                  fail_q;
   logic [ADDR_WIDTH-1:0] fail_addr_q;
   logic [2:0]            fail_elem_q;
   logic [DATA_WIDTH-1:0] fail_data_q;
   logic [CNT_WIDTH-1:0]  fail_cnt_q;
   logic                  miscompare;

   // NOTE: every variable gets a default before the case statement, so no path
   // leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d      = state_q;
      elem_d       = elem_q;
      phase_d      = phase_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      drain_d      = drain_q;
      tag_in       = '0;
      start_accept = 1'b0;
      write_op     = 1'b0;
      cur          = elem_info(elem_q);
      nxt          = elem_info(elem_q + 3'd1);

      case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               start_accept = 1'b1;
               state_d      = S_SETUP;
               elem_d       = '0;
               phase_d      = 1'b0;
               // Background must be on wdata during SETUP, ahead of E0's first write.
               wdata_d      = background(elem_info(3'd0).write_ones);
            end
         end

         S_SETUP: begin
            state_d = S_RUN;
            addr_d  = first_addr(cur);
         end

         S_RUN: begin
            write_op = cur.has_read ? (cur.has_write && phase_q) : 1'b1;
            if (!write_op) begin
               tag_in = '{valid:    1'b1,
                          expected: background(cur.read_ones),
                          addr:     addr_q,
                          element:  elem_q};
            end

            if (cur.has_read && cur.has_write && !phase_q) begin
               phase_d = 1'b1;
            end else begin
               phase_d = 1'b0;
               if (addr_q == final_addr(cur)) begin
                  if (elem_q == ELEM_LAST) begin
                     state_d = S_DRAIN;
                     drain_d = 1'b0;
                  end else begin
                     state_d = S_GAP;
                     elem_d  = elem_q + 3'd1;
                     wdata_d = background(nxt.write_ones);
                  end
               end else begin
                  addr_d = cur.down ? addr_q - ADDR_WIDTH'(1) : addr_q + ADDR_WIDTH'(1);
               end
            end
         end

         S_GAP: begin
            state_d = S_RUN;
            addr_d  = first_addr(cur);
         end

         S_DRAIN: begin
            if (drain_q) state_d = S_DONE;
            else         drain_d = 1'b1;
         end

         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         elem_q  <= '0;
         phase_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         drain_q <= 1'b0;
         // NOTE: the tag line is reset so that reads in flight when a run is
         // aborted are never compared against the next run's read data.
         tag1_q  <= '0;
         tag2_q  <= '0;
      end else begin
         state_q <= state_d;
         elem_q  <= elem_d;
         phase_q <= phase_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         drain_q <= drain_d;
         tag1_q  <= tag_in;
         tag2_q  <= tag1_q;
      end
   end

   assign miscompare = tag2_q.valid && (bus.rdata != tag2_q.expected);

   always_ff @(posedge clk) begin
      if (!rst_n || start_accept) begin
         fail_q      <= 1'b0;
         fail_addr_q <= '0;
         fail_elem_q <= '0;
         fail_data_q <= '0;
         fail_cnt_q  <= '0;
      end else if (miscompare) begin
         if (fail_cnt_q != '1) fail_cnt_q <= fail_cnt_q + CNT_WIDTH'(1);
         if (!fail_q) begin
            fail_q      <= 1'b1;
            fail_addr_q <= tag2_q.addr;
            fail_elem_q <= tag2_q.element;
            fail_data_q <= bus.rdata ^ tag2_q.expected;
         end
      end
   end

   assign bus.write_read   = write_op;
   assign bus.address      = addr_q;
   assign bus.wdata        = wdata_q;
   assign bus.busy         = (state_q == S_SETUP) || (state_q == S_RUN) ||
                             (state_q == S_GAP)   || (state_q == S_DRAIN);
   assign bus.done         = (state_q == S_DONE);
   assign bus.fail         = fail_q;
   assign bus.fail_addr    = fail_addr_q;
   assign bus.fail_element = fail_elem_q;
   assign bus.fail_data    = fail_data_q;
   assign bus.fail_cnt     = fail_cnt_q;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl (8-bit words, 16 addresses): memory model with injectable
// stuck-at faults, March C- reference model for the report and the per-cycle op trace.
module tb_mbist_march_ctrl;

   localparam int DW = 8;
   localparam int AW = 4;
   localparam int NA = 16;
   localparam int CW = 16;
   localparam int RUN_CYCLES = 1 + 10 * NA + 5 + 2;

   typedef struct packed {
      logic          wr;
      logic          chk_addr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } op_t;

   logic clk;
   logic rst_n;

   mbist_march_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

   mbist_march_ctrl #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .LAST_ADDR (NA - 1),
      .CNT_WIDTH (CW)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.master)
   );

   int tests = 0;
   int fails = 0;

   int            fault_addr = -1;
   logic [DW-1:0] sa1_mask   = '0;
   logic [DW-1:0] sa0_mask   = '0;
   logic          corrupt    = 1'b0;

   logic [DW-1:0] mem [NA];
   logic [DW-1:0] prev_wdata;
   logic [DW-1:0] rd_q1;
   op_t           trace [$];
   logic [32:0]   first_report;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog");
   end

   function automatic logic [DW-1:0] read_view(input int a, input logic [DW-1:0] v);
      return (a == fault_addr) ? ((v | sa1_mask) & ~sa0_mask) : v;
   endfunction

   // Memory: write uses the wdata of the previous cycle, read data appears 2 cycles later.
   always @(posedge clk) begin
      prev_wdata <= bus.wdata;
      if (bus.write_read === 1'b1) mem[bus.address] <= prev_wdata;
      rd_q1     <= read_view(int'(bus.address), mem[bus.address]);
      bus.rdata <= corrupt ? ~rd_q1 : rd_q1;
   end

   // March C- described element by element.
   function automatic bit has_rd(input int e);  return e != 0; endfunction
   function automatic bit has_wr(input int e);  return e != 5; endfunction
   function automatic bit is_down(input int e); return (e == 3) || (e == 4); endfunction
   function automatic logic [DW-1:0] rd_bg(input int e);
      return ((e == 2) || (e == 4)) ? 8'hFF : 8'h00;
   endfunction
   function automatic logic [DW-1:0] wr_bg(input int e);
      return ((e == 1) || (e == 3)) ? 8'hFF : 8'h00;
   endfunction

   task automatic predict(output bit f, output logic [AW-1:0] fa, output logic [2:0] fe,
                          output logic [DW-1:0] fd, output int cnt);
      logic [DW-1:0] m [NA];
      logic [DW-1:0] v;
      int a;
      f = 1'b0; fa = '0; fe = '0; fd = '0; cnt = 0;
      for (int i = 0; i < NA; i++) m[i] = 8'h5A;
      for (int e = 0; e < 6; e++) begin
         for (int k = 0; k < NA; k++) begin
            a = is_down(e) ? NA - 1 - k : k;
            if (has_rd(e)) begin
               v = read_view(a, m[a]);
               if (v != rd_bg(e)) begin
                  cnt++;
                  if (!f) begin
                     f = 1'b1; fa = AW'(a); fe = 3'(e); fd = v ^ rd_bg(e);
                  end
               end
            end
            if (has_wr(e)) m[a] = wr_bg(e);
         end
      end
   endtask

   task automatic run_test(input int restart_at, output int busy_cycles, output bit timed_out);
      int n;
      n = 0;
      busy_cycles = 0;
      timed_out = 1'b0;
      trace.delete();
      first_report = 'x;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      while (bus.done !== 1'b1) begin
         if (bus.busy === 1'b1) begin
            busy_cycles++;
            trace.push_back(op_t'{bus.write_read, 1'b1, bus.address, bus.wdata});
            if (busy_cycles == 1)
               first_report = {bus.done, bus.fail, bus.fail_addr, bus.fail_element,
                               bus.fail_data, bus.fail_cnt};
         end
         bus.start = (busy_cycles == restart_at);
         n++;
         if (n > 4 * RUN_CYCLES) begin
            timed_out = 1'b1;
            break;
         end
         @(negedge clk);
      end
      bus.start = 1'b0;
      tests++;
      if (timed_out) begin
         fails++;
         $display("FAIL run_timeout: done never rose after %0d cycles", n);
      end
   endtask

   task automatic check_trace(input string name);
      op_t exp_q [$];
      int  last;
      int  a;
      exp_q.push_back(op_t'{1'b0, 1'b0, 4'h0, 8'h00});
      last = 0;
      for (int e = 0; e < 6; e++) begin
         if (e > 0) exp_q.push_back(op_t'{1'b0, 1'b1, AW'(last), wr_bg(e)});
         for (int k = 0; k < NA; k++) begin
            a = is_down(e) ? NA - 1 - k : k;
            if (has_rd(e)) exp_q.push_back(op_t'{1'b0, 1'b1, AW'(a), wr_bg(e)});
            if (has_wr(e)) exp_q.push_back(op_t'{1'b1, 1'b1, AW'(a), wr_bg(e)});
            last = a;
         end
      end
      repeat (2) exp_q.push_back(op_t'{1'b0, 1'b1, AW'(last), 8'h00});

      tests++;
      if (trace.size() != exp_q.size()) begin
         fails++;
         $display("FAIL %s trace_len: got %0d expected %0d", name, trace.size(), exp_q.size());
      end
      for (int i = 0; i < trace.size() && i < exp_q.size(); i++) begin
         tests++;
         if (trace[i].wr !== exp_q[i].wr || trace[i].wdata !== exp_q[i].wdata ||
             (exp_q[i].chk_addr && trace[i].addr !== exp_q[i].addr)) begin
            fails++;
            $display("FAIL %s op[%0d]: got wr=%b addr=%0d wdata=%h expected wr=%b addr=%0d wdata=%h",
                     name, i, trace[i].wr, trace[i].addr, trace[i].wdata,
                     exp_q[i].wr, exp_q[i].addr, exp_q[i].wdata);
         end
      end
   endtask

   task automatic check_report(input string name, input int busy_cycles);
      bit            f;
      logic [AW-1:0] fa;
      logic [2:0]    fe;
      logic [DW-1:0] fd;
      int            cnt;
      predict(f, fa, fe, fd, cnt);
      tests++;
      if (busy_cycles != RUN_CYCLES) begin
         fails++;
         $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cycles, RUN_CYCLES);
      end
      tests++;
      if ({bus.done, bus.busy, bus.fail, bus.fail_addr, bus.fail_element, bus.fail_data} !==
          {1'b1, 1'b0, f, fa, fe, fd}) begin
         fails++;
         $display("FAIL %s report: got done=%b busy=%b fail=%b addr=%0d elem=%0d data=%h expected done=1 busy=0 fail=%b addr=%0d elem=%0d data=%h",
                  name, bus.done, bus.busy, bus.fail, bus.fail_addr, bus.fail_element,
                  bus.fail_data, f, fa, fe, fd);
      end
      tests++;
      if (bus.fail_cnt !== CW'(cnt)) begin
         fails++;
         $display("FAIL %s fail_cnt: got %0d expected %0d", name, bus.fail_cnt, cnt);
      end
   endtask

   task automatic set_fault(input int a, input logic [DW-1:0] s1, input logic [DW-1:0] s0);
      fault_addr = a;
      sa1_mask   = s1;
      sa0_mask   = s0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      tests++;
      if ({bus.write_read, bus.address, bus.wdata, bus.busy, bus.done, bus.fail, bus.fail_addr,
           bus.fail_element, bus.fail_data, bus.fail_cnt} !== '0) begin
         fails++;
         $display("FAIL reset_outputs: got wr=%b addr=%h wdata=%h busy=%b done=%b fail=%b cnt=%0d expected all 0",
                  bus.write_read, bus.address, bus.wdata, bus.busy, bus.done, bus.fail, bus.fail_cnt);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      tests++;
      if ({bus.busy, bus.done} !== 2'b00) begin
         fails++;
         $display("FAIL idle_after_reset: got busy=%b done=%b expected 0 0", bus.busy, bus.done);
      end
   endtask

   task automatic test_fault_free();
      int bc; bit to;
      set_fault(-1, '0, '0);
      run_test(0, bc, to);
      check_report("fault_free", bc);
      check_trace("fault_free");
   endtask

   task automatic test_stuck_at_1();
      int bc; bit to;
      set_fault(5, 8'h02, 8'h00);
      run_test(0, bc, to);
      tests++;
      if ({bus.fail, bus.fail_element, bus.fail_addr, bus.fail_data, bus.fail_cnt} !==
          {1'b1, 3'd1, 4'd5, 8'h02, 16'd3}) begin
         fails++;
         $display("FAIL stuck_at_1: got fail=%b elem=%0d addr=%0d data=%h cnt=%0d expected 1 1 5 02 3",
                  bus.fail, bus.fail_element, bus.fail_addr, bus.fail_data, bus.fail_cnt);
      end
      check_report("stuck_at_1", bc);
   endtask

   task automatic test_start_clears_report();
      int bc; bit to;
      set_fault(-1, '0, '0);
      run_test(0, bc, to);
      tests++;
      if (first_report !== '0) begin
         fails++;
         $display("FAIL clear_on_start: got report %h in first busy cycle expected 0", first_report);
      end
      check_report("clear_on_start", bc);
   endtask

   task automatic test_stuck_at_0();
      int bc; bit to;
      set_fault(9, 8'h00, 8'hFF);
      run_test(0, bc, to);
      tests++;
      if ({bus.fail, bus.fail_element, bus.fail_addr, bus.fail_data, bus.fail_cnt} !==
          {1'b1, 3'd2, 4'd9, 8'hFF, 16'd2}) begin
         fails++;
         $display("FAIL stuck_at_0: got fail=%b elem=%0d addr=%0d data=%h cnt=%0d expected 1 2 9 FF 2",
                  bus.fail, bus.fail_element, bus.fail_addr, bus.fail_data, bus.fail_cnt);
      end
      set_fault(-1, '0, '0);
   endtask

   task automatic test_reset_mid_test();
      int bc; bit to;
      set_fault(-1, '0, '0);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (90) @(negedge clk);  // inside E3 (busy cycles 85..116)
      rst_n   = 1'b0;
      corrupt = 1'b1;
      @(negedge clk);
      tests++;
      if ({bus.write_read, bus.address, bus.wdata, bus.busy, bus.done, bus.fail, bus.fail_cnt} !== '0) begin
         fails++;
         $display("FAIL mid_reset_outputs: got wr=%b addr=%h wdata=%h busy=%b done=%b fail=%b cnt=%0d expected all 0",
                  bus.write_read, bus.address, bus.wdata, bus.busy, bus.done, bus.fail, bus.fail_cnt);
      end
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      tests++;
      if ({bus.busy, bus.done, bus.fail, bus.fail_cnt} !== '0) begin
         fails++;
         $display("FAIL stale_compare: got busy=%b done=%b fail=%b cnt=%0d expected all 0",
                  bus.busy, bus.done, bus.fail, bus.fail_cnt);
      end
      corrupt = 1'b0;
      run_test(0, bc, to);
      check_report("after_mid_reset", bc);
      check_trace("after_mid_reset");
   endtask

   task automatic test_start_while_busy();
      int bc; bit to;
      set_fault(-1, '0, '0);
      run_test(50, bc, to);
      check_report("start_while_busy", bc);
      check_trace("start_while_busy");
   endtask

   task automatic test_random_faults();
      int bc; bit to;
      logic [DW-1:0] s1;
      for (int i = 0; i < 6; i++) begin
         case (i)
            0:       set_fault(0, 8'h00, 8'h01);
            1:       set_fault(NA - 1, 8'h80, 8'h00);
            default: begin
               s1 = DW'($urandom);
               set_fault(int'($urandom_range(0, NA - 1)), s1, DW'($urandom) & ~s1);
            end
         endcase
         run_test(0, bc, to);
         check_report($sformatf("random_fault_%0d", i), bc);
         check_trace($sformatf("random_fault_%0d", i));
      end
      set_fault(-1, '0, '0);
   endtask

   initial begin
      bus.start = 1'b0;
      test_reset();
      test_fault_free();
      test_stuck_at_1();
      test_start_clears_report();
      test_stuck_at_0();
      test_reset_mid_test();
      test_start_while_busy();
      test_random_faults();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
